ascii_wake_ctrl: RTL
====================

Name: ascii_wake_ctrl

Overview:
Upstream feeder of the core sleep/clock-gating stage. Accepts the incoming ASCII byte stream, buffers it in a byte FIFO, and tracks complete instructions, which are lines ending in the terminator byte. It produces the `new_ascii_instr_o` pulse and the `wake_from_sleep_o` level consumed by the sleep stage. It runs entirely on the ungated clock so it can wake a sleeping core.

Parameters:
- DEPTH, 16: FIFO depth in bytes; power of 2, minimum 4.
- TERM, 8'h0D: instruction terminator byte.
- HOLD_CYCLES, 40: cycles that wake stays high after the last pending line is consumed. Must exceed the sleep stage's 38-cycle busy delay.

Ports:
- clk_ungated_i, in, 1: free-running clock. Never gated.
- resetn, in, 1: asynchronous active-low reset.
- rx_valid_i, in, 1: upstream byte valid.
- rx_data_i, in, 8: upstream byte.
- rx_ready_o, out, 1: block can accept a byte.
- instr_rd_i, in, 1: core pops one byte.
- instr_valid_o, out, 1: FIFO non-empty.
- instr_data_o, out, 8: head byte, first-word-fall-through.
- instr_last_o, out, 1: head byte equals TERM.
- new_ascii_instr_o, out, 1: one-cycle pulse per completed line.
- wake_from_sleep_o, out, 1: wake/keep-awake request to the sleep stage.
- line_count_o, out, $clog2(DEPTH)+1: complete lines pending.
- overflow_o, out, 1: sticky forced-termination flag.

Behaviour:
- Reset values:
  - All pointers, counters, line_count_o, new_ascii_instr_o, wake_from_sleep_o and overflow_o are 0.
  - rx_ready_o = 1, instr_valid_o = 0.
  - instr_data_o is don't-care while instr_valid_o = 0.
  - Reset may arrive mid-operation; it discards FIFO contents and returns the FSM to IDLE immediately.
- FIFO storage and pointers:
  - Byte count is 0..DEPTH.
  - Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
  - Write happens when rx_valid_i && rx_ready_o.
  - Read happens when instr_rd_i && instr_valid_o. instr_rd_i while empty is ignored.
  - Simultaneous read and write: count unchanged, both pointers advance. Allowed when full, because the read frees a slot in the same cycle.
- rx_ready_o and instr_valid_o:
  - rx_ready_o = (count < DEPTH) || instr_rd_i.
  - instr_valid_o = (count != 0), derived from registered count.
  - A written byte is visible at the head on the cycle after acceptance (1-cycle latency).
- Forced termination:
  - Applies when a write occurs with count == DEPTH-1 and line_count == 0 (no read in the same cycle).
  - The stored byte is replaced by TERM and overflow_o is set.
  - overflow_o is cleared only by reset.
  - This prevents deadlock with a full FIFO holding no complete line.
- Line counting (line_count_o):
  - +1 when a TERM byte, original or forced, is written.
  - −1 when a TERM byte is popped.
  - Both in the same cycle: unchanged.
  - Cannot underflow or exceed DEPTH by construction.
- new_ascii_instr_o:
  - Registered; high for exactly one cycle, the cycle after a TERM write.
  - Back-to-back TERM writes give back-to-back pulses.
- Wake FSM:
  - States are IDLE, WAKE and HOLD; wake_from_sleep_o is registered and high in WAKE and HOLD.
  - IDLE → WAKE when a TERM write occurs this cycle, so wake rises the cycle after the terminator, coincident with the pulse.
  - WAKE → HOLD when line_count reaches 0 after a pop, i.e. next line_count == 0 with no TERM write that cycle. The hold counter loads HOLD_CYCLES-1.
  - HOLD: counter decrements each cycle; HOLD → IDLE when the counter is 0.
  - HOLD → WAKE when a TERM write occurs; this takes priority over expiry.
  - WAKE with a simultaneous TERM write and TERM pop: stays in WAKE.
- Partial lines (bytes without a terminator) never raise wake.

Test Plan:
1. Reset, send "ab\r" (0x61, 0x62, 0x0D) one byte per cycle, no reads:
   - new_ascii_instr_o pulses once, the cycle after 0x0D is accepted.
   - wake_from_sleep_o rises in the same cycle; line_count_o = 1.
   - instr_data_o = 0x61.
2. Pop 3 bytes:
   - instr_last_o high on the third pop; line_count_o goes to 0.
   - wake_from_sleep_o stays high for exactly 40 more cycles, then drops.
3. During HOLD at cycle 20, send "x\r":
   - FSM returns to WAKE and wake never deasserts.
   - After popping, the full 40-cycle hold restarts.
4. Send 15 bytes of 0x41 with no terminator (DEPTH=16), then 0x42:
   - The 16th stored byte reads 0x0D; overflow_o = 1; new_ascii_instr_o pulses.
   - rx_ready_o = 0 afterwards until a pop.
5. Full FIFO, drive rx_valid_i and instr_rd_i together for 4 cycles:
   - 4 bytes accepted, count stays 16, data order preserved across pointer wrap.
6. Assert resetn low mid-line, with 5 bytes queued and the FSM in WAKE:
   - Outputs return to reset values asynchronously; instr_valid_o = 0 and wake_from_sleep_o = 0.

Source files
------------

// File: rtl/ascii_wake_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ascii_wake_ctrl
// Brief   : ASCII byte FIFO with line tracking; raises wake for the sleep stage
// Rev     : 1.0  initial release
// ============================================================================
module ascii_wake_ctrl #(
  parameter int         DEPTH       = 16,
  parameter logic [7:0] TERM        = 8'h0D,
  parameter int         HOLD_CYCLES = 40
) (
  input  logic                     clk_ungated_i,
  input  logic                     resetn,
  input  logic                     rx_valid_i,
  input  logic [7:0]               rx_data_i,
  output logic                     rx_ready_o,
  input  logic                     instr_rd_i,
  output logic                     instr_valid_o,
  output logic [7:0]               instr_data_o,
  output logic                     instr_last_o,
  output logic                     new_ascii_instr_o,
  output logic                     wake_from_sleep_o,
  output logic [$clog2(DEPTH):0]   line_count_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_M1   = CW'(DEPTH - 1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAKE = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic [CW-1:0] line_count, line_next;
  logic [HW-1:0] hold_q, hold_d;
  state_t        state_q, state_d;
  logic          overflow, new_instr;

  logic       wr_en, rd_en, forced, term_wr, term_rd;
  logic [7:0] wr_byte, head;

  assign head          = mem[rd_ptr];
  assign instr_valid_o = (count != '0);
  assign rx_ready_o    = (count < DEPTH_C) || instr_rd_i;
  assign wr_en         = rx_valid_i && rx_ready_o;
  assign rd_en         = instr_rd_i && instr_valid_o;

  // A full FIFO with no terminator could never drain, so the last slot closes the line.
  assign forced  = wr_en && !rd_en && (count == DEPTH_M1) && (line_count == '0);
  assign wr_byte = forced ? TERM : rx_data_i;
  assign term_wr = wr_en && (wr_byte == TERM);
  assign term_rd = rd_en && (head == TERM);

  assign count_next = count + CW'(wr_en) - CW'(rd_en);
  assign line_next  = line_count + CW'(term_wr) - CW'(term_rd);

  assign instr_data_o      = head;
  assign instr_last_o      = instr_valid_o && (head == TERM);
  assign new_ascii_instr_o = new_instr;
  assign wake_from_sleep_o = (state_q != S_IDLE);
  assign line_count_o      = line_count;
  assign overflow_o        = overflow;

  always_ff @(posedge clk_ungated_i) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_byte;
    end
  end

  always_ff @(posedge clk_ungated_i or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      line_count <= '0;
      overflow   <= 1'b0;
      new_instr  <= 1'b0;
      state_q    <= S_IDLE;
      hold_q     <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count      <= count_next;
      line_count <= line_next;
      if (forced) overflow <= 1'b1;
      new_instr  <= term_wr;
      state_q    <= state_d;
      hold_q     <= hold_d;
    end
  end

  // A new terminator always beats hold expiry so wake never drops while work is pending.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (term_wr) state_d = S_WAKE;
      end
      S_WAKE: begin
        if (!term_wr && (line_next == '0)) begin
          state_d = S_HOLD;
          hold_d  = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (term_wr) begin
          state_d = S_WAKE;
        end else if (hold_q == '0) begin
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire
